// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the VGA raster generator: standard mode sets
// and a helper that sizes the position counters from the frame totals.
package vga_timing_pkg;

  typedef struct packed {
    int   h_active;
    int   h_fp;
    int   h_sync;
    int   h_bp;
    int   v_active;
    int   v_fp;
    int   v_sync;
    int   v_bp;
    logic hs_pol;
    logic vs_pol;
  } vga_mode_t;

  localparam vga_mode_t MODE_640X480 = '{
    h_active: 640,  h_fp: 16, h_sync: 96,  h_bp: 48,
    v_active: 480,  v_fp: 10, v_sync: 2,   v_bp: 33,
    hs_pol: 1'b0,   vs_pol: 1'b0
  };

  localparam vga_mode_t MODE_800X600 = '{
    h_active: 800,  h_fp: 40, h_sync: 128, h_bp: 88,
    v_active: 600,  v_fp: 1,  v_sync: 4,   v_bp: 23,
    hs_pol: 1'b1,   vs_pol: 1'b1
  };

  localparam vga_mode_t MODE_1280X1024 = '{
    h_active: 1280, h_fp: 48, h_sync: 112, h_bp: 248,
    v_active: 1024, v_fp: 1,  v_sync: 3,   v_bp: 38,
    hs_pol: 1'b1,   vs_pol: 1'b1
  };

  // Smallest counter width able to hold both H_TOTAL-1 and V_TOTAL-1.
  function automatic int min_cnt_w(input int h_total, input int v_total);
    int m;
    m = (h_total > v_total) ? h_total : v_total;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with async reset to a programmable value;
// a depth of zero degenerates to a wire.
module vga_delay_line #(
  parameter int                DEPTH   = 2,
  parameter int                WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_regs
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge pixel_clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
      end else begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: issues pixel requests ahead of the
// beam and realigns syncs/data enable with the fixed-latency returned pixels.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = MODE_1280X1024.h_active,
  parameter int H_FP     = MODE_1280X1024.h_fp,
  parameter int H_SYNC   = MODE_1280X1024.h_sync,
  parameter int H_BP     = MODE_1280X1024.h_bp,
  parameter int V_ACTIVE = MODE_1280X1024.v_active,
  parameter int V_FP     = MODE_1280X1024.v_fp,
  parameter int V_SYNC   = MODE_1280X1024.v_sync,
  parameter int V_BP     = MODE_1280X1024.v_bp,
  parameter bit HS_POL   = MODE_1280X1024.hs_pol,
  parameter bit VS_POL   = MODE_1280X1024.vs_pol,
  parameter int PIPE_LAT = 2,
  parameter int COLOR_W  = 4,
  parameter int CNT_W    = 12
) (
  input  logic                 pixel_clk,
  input  logic                 rst_n,
  input  logic [3*COLOR_W-1:0] pixel_color,
  output logic                 req_valid,
  output logic [CNT_W-1:0]     req_x,
  output logic [CNT_W-1:0]     req_y,
  output logic [COLOR_W-1:0]   VGA_BUS_R,
  output logic [COLOR_W-1:0]   VGA_BUS_G,
  output logic [COLOR_W-1:0]   VGA_BUS_B,
  output logic                 VGA_HS,
  output logic                 VGA_VS,
  output logic                 de,
  output logic                 frame_start,
  output logic                 line_start,
  output logic                 vblank
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG_C = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END_C = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] H_LAST_C = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] VS_BEG_C = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END_C = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] V_LAST_C = CNT_W'(V_TOTAL - 1);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
    $error("vga_timing_gen: every porch and sync width must be at least 1");
  end
  if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_active
    $error("vga_timing_gen: active region must be at least 1 pixel and 1 line");
  end
  if (PIPE_LAT < 0 || PIPE_LAT > 15) begin : g_bad_lat
    $error("vga_timing_gen: PIPE_LAT must be within 0..15");
  end
  if (CNT_W < min_cnt_w(H_TOTAL, V_TOTAL)) begin : g_bad_cnt_w
    $error("vga_timing_gen: CNT_W too narrow for the frame totals");
  end

  logic             run;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             hs_raw;
  logic             vs_raw;
  logic             hs_dly;
  logic             vs_dly;
  logic             valid_dly;

  // run holds the counters at the origin for one clock after reset release,
  // so the first request cycle is (0,0) with frame_start.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (h_cnt == H_LAST_C) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  assign req_x       = h_cnt;
  assign req_y       = v_cnt;
  assign req_valid   = run && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
  assign line_start  = run && (h_cnt == '0);
  assign vblank      = (v_cnt >= V_ACT_C);

  assign hs_raw = (h_cnt >= HS_BEG_C) && (h_cnt < HS_END_C);
  assign vs_raw = (v_cnt >= VS_BEG_C) && (v_cnt < VS_END_C);

  vga_delay_line #(
    .DEPTH   (PIPE_LAT),
    .WIDTH   (3),
    .RST_VAL (3'b000)
  ) u_sync_dly (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .d         ({hs_raw, vs_raw, req_valid}),
    .q         ({hs_dly, vs_dly, valid_dly})
  );

  // Final register lands syncs, de and pixel data on the same edge.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      VGA_BUS_R <= '0;
      VGA_BUS_G <= '0;
      VGA_BUS_B <= '0;
      de        <= 1'b0;
      VGA_HS    <= ~HS_POL;
      VGA_VS    <= ~VS_POL;
    end else begin
      VGA_BUS_R <= valid_dly ? pixel_color[COLOR_W-1:0]           : '0;
      VGA_BUS_G <= valid_dly ? pixel_color[2*COLOR_W-1:COLOR_W]   : '0;
      VGA_BUS_B <= valid_dly ? pixel_color[3*COLOR_W-1:2*COLOR_W] : '0;
      de        <= valid_dly;
      VGA_HS    <= ~(hs_dly ^ HS_POL);
      VGA_VS    <= ~(vs_dly ^ VS_POL);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for the raster generator in a small 8x6 mode, with a
// PIPE_LAT=2 instance and a PIPE_LAT=0 instance running side by side.
module tb_vga_timing_gen;

  logic        pixel_clk;
  logic        rst_n;

  logic [11:0] pixel_color;
  logic        req_valid, frame_start, line_start, vblank, de, vga_hs, vga_vs;
  logic [11:0] req_x, req_y;
  logic [3:0]  bus_r, bus_g, bus_b;

  logic [11:0] pixel_color0;
  logic        req_valid0, frame_start0, line_start0, vblank0, de0, vga_hs0, vga_vs0;
  logic [11:0] req_x0, req_y0;
  logic [3:0]  bus_r0, bus_g0, bus_b0;

  logic [11:0] x_d1, x_d2;

  int errors = 0;
  int checks = 0;
  int hs_low_cnt, vs_high_cnt, de_cnt, fs_cnt;

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_LAT(2), .COLOR_W(4), .CNT_W(12)
  ) u_dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .pixel_color(pixel_color),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y),
    .VGA_BUS_R(bus_r), .VGA_BUS_G(bus_g), .VGA_BUS_B(bus_b),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs), .de(de),
    .frame_start(frame_start), .line_start(line_start), .vblank(vblank)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .PIPE_LAT(0), .COLOR_W(4), .CNT_W(12)
  ) u_dut0 (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .pixel_color(pixel_color0),
    .req_valid(req_valid0), .req_x(req_x0), .req_y(req_y0),
    .VGA_BUS_R(bus_r0), .VGA_BUS_G(bus_g0), .VGA_BUS_B(bus_b0),
    .VGA_HS(vga_hs0), .VGA_VS(vga_vs0), .de(de0),
    .frame_start(frame_start0), .line_start(line_start0), .vblank(vblank0)
  );

  initial pixel_clk = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  // Pixel source: returns {B=A, G=5, R=x} two clocks after the request.
  always @(posedge pixel_clk) begin
    x_d1 <= req_x;
    x_d2 <= x_d1;
  end
  assign pixel_color  = {4'hA, 4'h5, x_d2[3:0]};
  assign pixel_color0 = {4'hA, 4'h5, req_x0[3:0]};

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ":req_valid"}, -1, 32'(req_valid), 32'd0);
    chk({tag, ":req_x"}, -1, 32'(req_x), 32'd0);
    chk({tag, ":req_y"}, -1, 32'(req_y), 32'd0);
    chk({tag, ":frame_start"}, -1, 32'(frame_start), 32'd0);
    chk({tag, ":line_start"}, -1, 32'(line_start), 32'd0);
    chk({tag, ":vblank"}, -1, 32'(vblank), 32'd0);
    chk({tag, ":de"}, -1, 32'(de), 32'd0);
    chk({tag, ":bus"}, -1, 32'({bus_b, bus_g, bus_r}), 32'd0);
    chk({tag, ":hs"}, -1, 32'(vga_hs), 32'd1);
    chk({tag, ":vs"}, -1, 32'(vga_vs), 32'd0);
    chk({tag, ":de0"}, -1, 32'(de0), 32'd0);
    chk({tag, ":hs0"}, -1, 32'(vga_hs0), 32'd1);
  endtask

  // Expected values for request cycle k (k=0 is the first request cycle).
  task automatic check_cycle(input int k);
    int h, v, j, hj, vj;
    logic ev, ede, ehs, evs;
    h  = k % 8;
    v  = (k / 8) % 6;
    ev = (h < 4) && (v < 3);
    chk("req_x", k, 32'(req_x), 32'(h));
    chk("req_y", k, 32'(req_y), 32'(v));
    chk("req_valid", k, 32'(req_valid), 32'(ev));
    chk("frame_start", k, 32'(frame_start), 32'((k % 48) == 0));
    chk("line_start", k, 32'(line_start), 32'(h == 0));
    chk("vblank", k, 32'(vblank), 32'(v >= 3));

    hj = 0; vj = 0; ede = 1'b0; ehs = 1'b1; evs = 1'b0;
    if (k >= 3) begin
      j   = k - 3;
      hj  = j % 8;
      vj  = (j / 8) % 6;
      ede = (hj < 4) && (vj < 3);
      ehs = !((hj >= 5) && (hj < 7));
      evs = (vj == 4);
    end
    chk("de", k, 32'(de), 32'(ede));
    chk("bus_r", k, 32'(bus_r), ede ? 32'(hj) : 32'd0);
    chk("bus_g", k, 32'(bus_g), ede ? 32'h5 : 32'd0);
    chk("bus_b", k, 32'(bus_b), ede ? 32'hA : 32'd0);
    chk("hs", k, 32'(vga_hs), 32'(ehs));
    chk("vs", k, 32'(vga_vs), 32'(evs));

    hj = 0; vj = 0; ede = 1'b0; ehs = 1'b1; evs = 1'b0;
    if (k >= 1) begin
      j   = k - 1;
      hj  = j % 8;
      vj  = (j / 8) % 6;
      ede = (hj < 4) && (vj < 3);
      ehs = !((hj >= 5) && (hj < 7));
      evs = (vj == 4);
    end
    chk("de0", k, 32'(de0), 32'(ede));
    chk("bus_r0", k, 32'(bus_r0), ede ? 32'(hj) : 32'd0);
    chk("hs0", k, 32'(vga_hs0), 32'(ehs));
    chk("vs0", k, 32'(vga_vs0), 32'(evs));

    if (k >= 3 && k < 51) begin
      if (!vga_hs) hs_low_cnt++;
      if (vga_vs)  vs_high_cnt++;
      if (de)      de_cnt++;
    end
    if (frame_start) fs_cnt++;
  endtask

  task automatic run_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge pixel_clk);
      check_cycle(k);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    hs_low_cnt = 0; vs_high_cnt = 0; de_cnt = 0; fs_cnt = 0;

    #3 rst_n = 1'b0;
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    check_reset_state("reset");

    rst_n = 1'b1;
    #1;
    chk("prerun:req_valid", -1, 32'(req_valid), 32'd0);
    chk("prerun:frame_start", -1, 32'(frame_start), 32'd0);

    run_cycles(106);
    chk("hs_low_per_frame", 0, 32'(hs_low_cnt), 32'd12);
    chk("vs_high_per_frame", 0, 32'(vs_high_cnt), 32'd8);
    chk("de_per_frame", 0, 32'(de_cnt), 32'd12);
    chk("frame_starts", 0, 32'(fs_cnt), 32'd3);

    // Mid-line reset at request position h=2, v=1 of the third frame.
    @(posedge pixel_clk);
    #2;
    chk("midrst:pre_x", 106, 32'(req_x), 32'd2);
    chk("midrst:pre_y", 106, 32'(req_y), 32'd1);
    chk("midrst:pre_valid", 106, 32'(req_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    check_reset_state("midrst_hold");

    rst_n = 1'b1;
    #1;
    chk("restart:req_valid", -1, 32'(req_valid), 32'd0);
    fs_cnt = 0;
    run_cycles(52);
    chk("restart_frame_starts", 0, 32'(fs_cnt), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator and pixel output stage for the VGA path. It replaces the fixed 1280x1024 sync generator with a generator whose horizontal and vertical timings, sync polarities and channel width are all parameters. It issues pixel requests ahead of the beam to cover a fixed-latency pixel source such as a frame-buffer read or palette lookup. It realigns syncs and data enable to the returned pixel data and emits frame, line and vertical-blank markers for the frame-buffer controller.

## Interface
- H_ACTIVE, 1280, visible pixels per line
- H_FP, 48, horizontal front porch (clocks)
- H_SYNC, 112, horizontal sync width
- H_BP, 248, horizontal back porch
- V_ACTIVE, 1024, visible lines
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 3, vertical sync width
- V_BP, 38, vertical back porch
- HS_POL, 1, active level of VGA_HS (1 = positive)
- VS_POL, 1, active level of VGA_VS
- PIPE_LAT, 2, clocks from request to valid `pixel_color`; range 0..15
- COLOR_W, 4, bits per colour channel
- CNT_W, 12, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports (clock and reset first):
- pixel_clk  in  1  pixel clock
- rst_n  in  1  reset, asynchronous, active-low
- pixel_color  in  3*COLOR_W  {B,G,R}; R = [COLOR_W-1:0]
- req_valid  out  1  request for the pixel at (req_x, req_y)
- req_x  out  CNT_W  requested column
- req_y  out  CNT_W  requested line
- VGA_BUS_R / VGA_BUS_G / VGA_BUS_B  out  COLOR_W each  pixel outputs
- VGA_HS  out  1  horizontal sync
- VGA_VS  out  1  vertical sync
- de  out  1  output pixel visible, aligned with VGA_BUS_*
- frame_start  out  1  one-clock pulse at request position (0,0)
- line_start  out  1  one-clock pulse at the start of every line (h=0)
- vblank  out  1  high while the request counter is at v ≥ V_ACTIVE

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way.
- Line order: active, front porch, sync, back porch. Frame order is the same.
- `h_cnt` counts 0..H_TOTAL-1. On wrap it returns to 0, and `v_cnt` increments, wrapping at V_TOTAL-1 to 0.
- `run` flag:
  - Cleared by reset; set on the first clock edge after release.
  - Counters hold at 0 while `run`=0.
- Request stage, derived from the counter registers:
  - req_x = h_cnt, req_y = v_cnt.
  - req_valid = run & (h_cnt<H_ACTIVE) & (v_cnt<V_ACTIVE).
  - frame_start = run & h_cnt==0 & v_cnt==0.
  - line_start = run & h_cnt==0.
  - vblank = v_cnt ≥ V_ACTIVE.
- Sync stage:
  - hs_raw is active when H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC. vs_raw is defined the same way on v_cnt.
  - hs_raw, vs_raw and req_valid pass through a delay line of PIPE_LAT stages, then one output register.
- Output register:
  - VGA_BUS_* = pixel_color when the delayed valid is 1, else 0.
  - de = delayed valid.
  - VGA_HS = delayed hs_raw XNOR HS_POL. VGA_VS = delayed vs_raw XNOR VS_POL.
- Reset values:
  - Counters 0, run 0, req_valid 0, frame_start 0, line_start 0.
  - vblank 0; VGA_BUS_* 0; de 0.
  - VGA_HS = !HS_POL, VGA_VS = !VS_POL.
  - All delay-line stages hold the inactive value.
- Reset mid-frame: all state returns to the values above immediately. Timing restarts at (0,0) with frame_start on the first request cycle.
- Parameter legality, checked by elaboration assertion:
  - Every porch and sync ≥ 1.
  - H_ACTIVE and V_ACTIVE ≥ 1.
  - PIPE_LAT ≤ 15.

## Timing
- Request to output: PIPE_LAT+1 clocks. `pixel_color` is sampled exactly PIPE_LAT clocks after the matching req_valid cycle.
- The source must return one pixel per request with fixed latency; there is no backpressure.
- VGA_HS, VGA_VS, de and VGA_BUS_* change on the same edge and stay mutually aligned.
- frame_start and line_start are undelayed, in the request domain.
- First request: the clock after the first edge following reset release.
- End of frame: the last pixel (H_ACTIVE-1, V_ACTIVE-1) is followed by porch clocks. After the wrap, the next frame's frame_start coincides with line_start.

## Structure
- Package `vga_timing_pkg`:
  - Mode constant sets for 640x480@60, 800x600@60 and 1280x1024@60, covering all eight timing values plus polarities.
  - A function computing the minimum CNT_W from the totals.
- Sub-module `vga_delay_line`:
  - Parameters DEPTH and WIDTH; DEPTH=0 is a passthrough.
  - Async active-low reset to a RST_VAL parameter.
  - Instantiated once for the {hs_raw, vs_raw, valid} bundle.

## Test plan
Small mode used throughout: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), PIPE_LAT=2, COLOR_W=4, HS_POL=0, VS_POL=1.
- Reset release → frame_start at the first request cycle with req_x=0, req_y=0, req_valid=1. de first rises 3 clocks later.
- Drive pixel_color=12'h000+req_x delayed 2 clocks → VGA_BUS_R shows 0,1,2,3 on de cycles, and 0 in the 4 blanking clocks.
- Horizontal timing:
  - VGA_HS is low for exactly 2 clocks per line.
  - It falls 3+5=8 clocks after req_x=0 (request h=5 plus latency).
  - The line period is 8 clocks.
- Vertical timing:
  - VGA_VS is high for exactly 8 clocks (1 line) per 48-clock frame.
  - vblank is high on request lines 3..5.
  - frame_start period is 48 clocks.
- Assert rst_n mid-line at h=2, v=1 → outputs go to reset values asynchronously. After release the timing restarts at (0,0) with no stray de.
- PIPE_LAT=0 build → de lags req_valid by exactly 1 clock. Default 1280x1024 build → frame period 1688×1066 clocks.
